// File: rtl/fir3_inverse_pkg.sv
// Shared constants and FSM encoding for the three-tap FIR inverse filter.
package fir3_inverse_pkg;

  localparam int OPERAND_SIZE = 8;
  localparam int PRODUCT_SIZE = 2 * OPERAND_SIZE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P1   = 2'd1,
    S_P2   = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fir3_inverse_arith.sv
// Arithmetic primitives for the inverse filter: a combinational radix-2 Booth
// multiplier and a carry-lookahead adder built from 4-bit lookahead groups.
module booth_mult
  import fir3_inverse_pkg::*;
#(
  parameter int W = OPERAND_SIZE,
  parameter int P = PRODUCT_SIZE
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [P-1:0] p_o
);

  logic [P-1:0] a_ext;
  logic [W:0]   b_pair;
  logic [P-1:0] sum;

  always_comb begin
    a_ext  = P'($signed(a_i));
    b_pair = {b_i, 1'b0};
    sum    = '0;
    // Recode each adjacent bit pair of b into {-1, 0, +1} times a shifted copy of a.
    for (int i = 0; i < W; i++) begin
      case (b_pair[i +: 2])
        2'b01:   sum = sum + (a_ext << i);
        2'b10:   sum = sum - (a_ext << i);
        default: sum = sum;
      endcase
    end
    p_o = sum;
  end

endmodule

module cla_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o
);

  localparam int NG = (N + 3) / 4;
  localparam int NP = NG * 4;

  logic [NP-1:0] gen, prop, s_pad;
  logic [3:0]    g, p, cc;
  logic          c;

  always_comb begin
    gen   = NP'(a_i) & NP'(b_i);
    prop  = NP'(a_i) ^ NP'(b_i);
    s_pad = '0;
    g     = '0;
    p     = '0;
    cc    = '0;
    c     = cin_i;
    for (int gi = 0; gi < NG; gi++) begin
      g     = gen[gi*4 +: 4];
      p     = prop[gi*4 +: 4];
      cc[0] = c;
      cc[1] = g[0] | (p[0] & c);
      cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      c     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | ((&p) & c);
      s_pad[gi*4 +: 4] = p ^ cc;
    end
    sum_o = s_pad[N-1:0];
  end

endmodule

// File: rtl/fir3_inverse.sv
// Sequential deconvolver for y = 2^K*x[n] + c1*x[n-1] + c2*x[n-2]; one shared
// multiplier is stepped over the two history taps, all arithmetic mod 2^(2*WIDTH).
//
// state  | meaning
// IDLE   | ready for y; latches y and coefficients on handshake
// P1     | acc <= acc - h1*k1
// P2     | x <= (acc - h2*k2) >>> K, raise out_valid
// DONE   | hold x until out_ready, then shift history
module fir3_inverse
  import fir3_inverse_pkg::*;
#(
  parameter int WIDTH = OPERAND_SIZE,
  parameter int K     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   y,
  input  logic [WIDTH-1:0]     c1,
  input  logic [WIDTH-1:0]     c2,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     x
);

  localparam int PW = 2 * WIDTH;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [PW-1:0]    acc_q;
  logic [WIDTH-1:0] k1_q, k2_q, h1_q, h2_q, x_q;

  logic [WIDTH-1:0] op_a, op_b;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    diff;
  logic [WIDTH-1:0] x_d;

  assign op_a = (state_q == S_P2) ? h2_q : h1_q;
  assign op_b = (state_q == S_P2) ? k2_q : k1_q;

  booth_mult #(.W(WIDTH), .P(PW)) u_mult (
    .a_i (op_a),
    .b_i (op_b),
    .p_o (prod)
  );

  cla_adder #(.N(PW)) u_sub (
    .a_i   (acc_q),
    .b_i   (~prod),
    .cin_i (1'b1),
    .sum_o (diff)
  );

  // Low WIDTH bits of an arithmetic right shift by K are just diff[K +: WIDTH].
  assign x_d = diff[K +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      h1_q        <= '0;
      h2_q        <= '0;
      x_q         <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      h1_q        <= '0;
      h2_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          acc_q      <= y;
          k1_q       <= c1;
          k2_q       <= c2;
          in_ready_q <= 1'b0;
          state_q    <= S_P1;
        end
        S_P1: begin
          acc_q   <= diff;
          state_q <= S_P2;
        end
        S_P2: begin
          x_q         <= x_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          h2_q        <= h1_q;
          h1_q        <= x_q;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x         = x_q;

endmodule

// File: tb/tb_fir3_inverse.sv
// Directed bench for fir3_inverse: K=0 instance for the main sequences, K=7 instance for wrap-around.
module tb_fir3_inverse;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic               in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic signed [15:0] y = '0;
  logic signed [7:0]  c1 = '0, c2 = '0;
  logic               in_ready, out_valid;
  logic signed [7:0]  x;

  logic               in_valid7 = 1'b0, flush7 = 1'b0, out_ready7 = 1'b1;
  logic signed [15:0] y7 = '0;
  logic signed [7:0]  c17 = '0, c27 = '0;
  logic               in_ready7, out_valid7;
  logic signed [7:0]  x7;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fir3_inverse #(.WIDTH(8), .K(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .y(y),
    .c1(c1), .c2(c2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .x(x)
  );

  fir3_inverse #(.WIDTH(8), .K(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7), .y(y7),
    .c1(c17), .c2(c27), .flush(flush7), .out_valid(out_valid7), .out_ready(out_ready7), .x(x7)
  );

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts #1 after an edge with the K=0 instance idle; returns #1 after the edge that raises out_valid.
  task automatic send(input logic signed [15:0] yv, input logic signed [7:0] c1v,
                      input logic signed [7:0] c2v, input logic signed [7:0] c1_late,
                      input int exp_x, input string tag);
    chk_eq({tag, "_in_ready"}, int'(in_ready), 1);
    in_valid = 1'b1; y = yv; c1 = c1v; c2 = c2v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c1 = c1_late;
    chk_eq({tag, "_busy"}, int'(in_ready), 0);
    chk_eq({tag, "_ov_p1"}, int'(out_valid), 0);
    @(posedge clk); #1;
    chk_eq({tag, "_ov_p2"}, int'(out_valid), 0);
    @(posedge clk); #1;
    chk_eq({tag, "_ov_done"}, int'(out_valid), 1);
    chk_eq({tag, "_x"}, int'(x), exp_x);
  endtask

  task automatic step_idle(input string tag);
    @(posedge clk); #1;
    chk_eq({tag, "_ret_rdy"}, int'(in_ready), 1);
    chk_eq({tag, "_ret_ov"}, int'(out_valid), 0);
  endtask

  task automatic send7(input logic signed [15:0] yv, input logic signed [7:0] c1v,
                       input logic signed [7:0] c2v, input int exp_x, input string tag);
    in_valid7 = 1'b1; y7 = yv; c17 = c1v; c27 = c2v;
    @(posedge clk); #1;
    in_valid7 = 1'b0;
    @(posedge clk); #1;
    chk_eq({tag, "_ov_p2"}, int'(out_valid7), 0);
    @(posedge clk); #1;
    chk_eq({tag, "_ov_done"}, int'(out_valid7), 1);
    chk_eq({tag, "_x"}, int'(x7), exp_x);
    @(posedge clk); #1;
    chk_eq({tag, "_ret_rdy"}, int'(in_ready7), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_in_ready", int'(in_ready), 1);
    chk_eq("rst_out_valid", int'(out_valid), 0);
    chk_eq("rst_x", int'(x), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic inversion, K=0, c1=2, c2=-1
    send(16'sd3, 8'sd2, -8'sd1, 8'sd2, 3, "basic0");   step_idle("basic0");
    send(16'sd1, 8'sd2, -8'sd1, 8'sd2, -5, "basic1");  step_idle("basic1");
    send(-16'sd6, 8'sd2, -8'sd1, 8'sd2, 7, "basic2");  step_idle("basic2");

    // Coefficient latch: h1=7, h2=-5; 20 - 2*7 + (-5) = 1 (with c1=5 it would be -20)
    send(16'sd20, 8'sd2, -8'sd1, 8'sd5, 1, "coef");    step_idle("coef");

    // Backpressure with zero coefficients: x = y
    out_ready = 1'b0;
    send(-16'sd3, 8'sd0, 8'sd0, 8'sd0, -3, "bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_eq("bp_hold_ov", int'(out_valid), 1);
      chk_eq("bp_hold_x", int'(x), -3);
      chk_eq("bp_hold_rdy", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    step_idle("bp");

    // Flush while in P2
    in_valid = 1'b1; y = 16'sd50; c1 = 8'sd3; c2 = 8'sd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_eq("flush_p2_ov", int'(out_valid), 0);
    chk_eq("flush_p2_rdy", int'(in_ready), 1);
    @(posedge clk); #1;
    chk_eq("flush_p2_ov_after", int'(out_valid), 0);
    send(16'sd9, 8'sd17, -8'sd33, 8'sd17, 9, "flush_hist"); step_idle("flush_hist");

    // Flush coincident with output handshake: h1=9 so 4 - 9 = -5, then history must be zero
    out_ready = 1'b0;
    send(16'sd4, 8'sd1, 8'sd0, 8'sd1, -5, "fh");
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_eq("fh_ov", int'(out_valid), 0);
    chk_eq("fh_rdy", int'(in_ready), 1);
    send(16'sd9, 8'sd1, 8'sd1, 8'sd1, 9, "fh_hist");   step_idle("fh_hist");

    // Wrap-around on K=7 instance: prime h1=h2=-128, then 0xBF80 -> 127
    send7(16'shC000, 8'sd0, 8'sd0, -128, "wrap_prime0");
    send7(16'shC000, 8'sd0, 8'sd0, -128, "wrap_prime1");
    send7(16'shBF80, -8'sd128, -8'sd128, 127, "wrap");

    // Asynchronous reset mid-P1, with h1=9 held beforehand
    in_valid = 1'b1; y = 16'sd100; c1 = 8'sd1; c2 = 8'sd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_rdy", int'(in_ready), 1);
    chk_eq("arst_ov", int'(out_valid), 0);
    chk_eq("arst_x", int'(x), 0);
    chk_eq("arst_x7", int'(x7), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'sd11, 8'sd3, 8'sd3, 8'sd3, 11, "arst_hist"); step_idle("arst_hist");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir3_inverse.md
# fir3_inverse

Sequential inverse (deconvolving) filter for the three-tap signed FIR, y[n] = 2^K·x[n] + c1·x[n-1] + c2·x[n-2]. Accepts one 2·WIDTH-bit filter output per handshake and recovers the WIDTH-bit input sample exactly as x[n] = (y[n] − c1·x[n-1] − c2·x[n-2]) >>> K, using modulo-2^(2·WIDTH) arithmetic. A single shared Booth multiplier is time-multiplexed over two cycles. The block sits at the receive end of the filter chain and feeds the self-check / loopback datapath.

## Interface
- WIDTH, 8, sample and coefficient width; equals the shared `OPERAND_SIZE`.
- K, 0, log2 of the leading coefficient c0; legal range 0..WIDTH-1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  y sample offered.
- in_ready  out  1  block can accept y.
- y  in  2·WIDTH  signed filter output.
- c1, c2  in  WIDTH  signed tap coefficients; sampled on input handshake.
- flush  in  1  synchronous clear of history and any sample in flight.
- out_valid  out  1  recovered sample available.
- out_ready  in  1  downstream accepts sample.
- x  out  WIDTH  signed recovered sample.

## Operation
- All values are two's complement signed. Products are 2·WIDTH bits. All sums and differences are 2·WIDTH bits and wrap; no saturation. This inverts any forward wrap exactly, because 2^K·x always fits in 2·WIDTH bits.
- History registers: h1 = x[n-1], h2 = x[n-2]. Both are 0 after reset and after flush.
- FSM states: IDLE, P1, P2, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, register acc ← y, k1 ← c1, k2 ← c2, then go to P1.
- P1: multiplier operands are (h1, k1); acc ← acc − product; go to P2.
- P2:
  - Multiplier operands are (h2, k2).
  - x ← low WIDTH bits of ((acc − product) >>> K), arithmetic shift.
  - out_valid ← 1; go to DONE.
- DONE:
  - out_valid = 1 and x is held stable until out_ready = 1.
  - On that handshake: h2 ← h1, h1 ← x, out_valid ← 0, go to IDLE.
- in_ready = 0 in P1, P2 and DONE. in_valid is ignored in those states.
- flush:
  - When high at a clock edge, in any state: h1 = h2 = 0, out_valid = 0, state ← IDLE.
  - flush has priority over an input handshake and over an output handshake on the same edge. The pending sample is discarded and history is not updated.
- Coefficient changes after the input handshake have no effect on the sample in flight.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, x 0, acc/k1/k2/h1/h2 0.
- Latency: input handshake at edge E gives out_valid = 1 with x valid immediately after edge E+2.
- Minimum initiation interval is 4 cycles (out_ready held high): IDLE, P1, P2, DONE.
- in_ready and out_valid are decoded from state registers only. There is no combinational path from in_valid or out_ready to any output.
- Reset asserted mid-operation aborts the sample. All registers return to reset values asynchronously.

## Structure
- The shared package/header holds:
  - `OPERAND_SIZE`;
  - the FSM state encoding (IDLE/P1/P2/DONE, 2 bits);
  - the product width 2·`OPERAND_SIZE`.
- One instance of the existing combinational booth_mult sub-module, with operands muxed by state.
- Subtraction uses the existing 2·WIDTH carry-lookahead adder. Inputs are the inverted product and cin = 1.

## Test plan
- **Basic inversion.** K=0, c1=2, c2=−1; feed y = 3, 1, −6 with out_ready high → x = 3, −5, 7; each out_valid exactly 2 cycles after acceptance; 4-cycle spacing.
- **Wrap-around.** K=7, c1=c2=−128, history primed to h1 = h2 = −128; feed y = 0xBF80 (−16512) → x = 127.
- **Backpressure.**
  - Hold out_ready low 5 cycles after out_valid: x and out_valid stay stable and in_ready stays 0.
  - When out_ready rises, the handshake occurs and in_ready is 1 on the next cycle.
- **Coefficient latch.** Change c1 from 2 to 5 in cycle P1 → the result still uses 2.
- **Flush.**
  - Assert flush in P2 → out_valid stays 0, history is zero.
  - Next y = 9 (K=0) → x = 9 regardless of c1 and c2.
  - flush coincident with an out_ready handshake → history not updated.
- **Reset.** Assert rst_n low mid-P1 → outputs go immediately to reset values; after release, the first sample decodes with zero history.
